param_register_file: RTL and testbench
======================================

Name: param_register_file

Overview:
- Parametrised successor to the 4x4 datapath register file used by the MIPS processor.
- Width and depth are configurable; two asynchronous read ports and one synchronous write port.
- Register 0 is hardwired to zero, per MIPS convention.
- Adds synchronous reset, a debug LED register holding the last written value, and a saturating write counter.
- Optional same-cycle write-to-read bypass for use in the pipelined datapath.

Parameters:
- DATA_W, 8: register and data width in bits; minimum 2.
- ADDR_W, 3: address width; depth = 2**ADDR_W registers.
- CNT_W, 8: width of the accepted-write counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- rd_addr1  input  ADDR_W  read port 1 address.
- rd_addr2  input  ADDR_W  read port 2 address.
- rd_data1  output  DATA_W  read port 1 data, combinational.
- rd_data2  output  DATA_W  read port 2 data, combinational.
- wr_en  input  1  write enable.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data.
- led  output  DATA_W  debug LED register.
- wr_count  output  CNT_W  count of accepted writes since reset.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. No asynchronous reset path exists.
- Reset (rst=1 at rising edge):
  - All registers become 0.
  - led becomes 0.
  - wr_count becomes 0.
  - rst has priority over any simultaneous write.
- Reads:
  - rd_dataN = reg[rd_addrN], purely combinational, zero latency.
  - Address 0 always reads 0.
  - Both ports may read the same address in the same cycle.
- Accepted write: rising edge with rst=0, wr_en=1 and wr_addr!=0.
  - reg[wr_addr] <= wr_data.
  - Visible on read ports from the following cycle.
- Write to address 0:
  - Storage unchanged; led unchanged; wr_count unchanged.
  - Not an accepted write.
- led update on each accepted write:
  - led[DATA_W-2:0] <= wr_data[DATA_W-2:0].
  - led[DATA_W-1] <= 1, marking "written since reset".
  - Otherwise led holds its value.
- wr_count:
  - Increments by 1 on each accepted write.
  - Saturates at 2**CNT_W-1; never wraps.
- Writes to the same address on consecutive cycles: the last write wins; no hazard.
- X/undefined addresses are not handled; the bench must drive defined values.
- No FSM. State is:
  - register array of (2**ADDR_W - 1) x DATA_W; entry 0 is not stored.
  - led.
  - wr_count.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - If wr_en=1, wr_addr!=0 and wr_addr==rd_addrN in the same cycle, rd_dataN = wr_data combinationally (write-through forwarding).
  - Applies to each read port independently.
  - Not applied while rst=1; the port returns the stored value.
- Undefined:
  - Reads return the pre-edge stored value.
  - The new value appears the cycle after the write.

Decomposition:
- Shared package regfile_pkg:
  - Default constants REGFILE_DATA_W=8, REGFILE_ADDR_W=3, REGFILE_CNT_W=8.
  - ZERO_REG_ADDR=0.
- One natural sub-module: regfile_sat_counter, a CNT_W-bit saturating counter with synchronous reset and inc input.
- Read muxes and bypass logic stay inline.

Test Plan (DATA_W=8, ADDR_W=3, CNT_W=8):
- Reset: assert rst 2 cycles after random writes -> all 8 addresses read 0x00, led=0x00, wr_count=0.
- Basic write/read:
  - Write 0x5A to r3.
  - Read r3 on port1 and port2 next cycle -> both 0x5A.
  - led=0xDA, wr_count=1.
- Zero register: write 0xFF to r0 -> r0 reads 0x00, led and wr_count unchanged.
- Bypass, same cycle as "write 0x21 to r5" with rd_addr1=5 (r5 previously 0x10):
  - REGFILE_BYPASS_EN defined -> rd_data1=0x21.
  - Undefined -> rd_data1=0x10, then 0x21 the next cycle.
- Saturation: 300 accepted writes -> wr_count=0xFF and stays 0xFF; the last write value is readable.
- Reset collision: rst=1 and wr_en=1 (r2 <- 0x77) on the same edge -> r2=0x00, led=0x00, wr_count=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants for the parametrised register file
package regfile_pkg;

  localparam int REGFILE_DATA_W = 8;
  localparam int REGFILE_ADDR_W = 3;
  localparam int REGFILE_CNT_W  = 8;
  localparam int ZERO_REG_ADDR  = 0;

endpackage : regfile_pkg

// File: rtl/param_register_file_if.sv
// rtl/param_register_file_if.sv - read/write/debug bus of the register file
interface param_register_file_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = REGFILE_DATA_W,
  parameter int ADDR_W = REGFILE_ADDR_W,
  parameter int CNT_W  = REGFILE_CNT_W
);

  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] led;
  logic [CNT_W-1:0]  wr_count;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
    input  rd_data1, rd_data2, led, wr_count
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
    output rd_data1, rd_data2, led, wr_count
  );

endinterface : param_register_file_if

// File: rtl/regfile_sat_counter.sv
// rtl/regfile_sat_counter.sv - CNT_W-bit saturating up-counter, sync reset
module regfile_sat_counter
  import regfile_pkg::*;
#(
  parameter int CNT_W = REGFILE_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Holds at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule : regfile_sat_counter

// File: rtl/param_register_file.sv
// rtl/param_register_file.sv - 2R1W register file, r0 hardwired zero; REGFILE_BYPASS_EN enables write-to-read forwarding
module param_register_file
  import regfile_pkg::*;
#(
  parameter int DATA_W = REGFILE_DATA_W,
  parameter int ADDR_W = REGFILE_ADDR_W,
  parameter int CNT_W  = REGFILE_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  param_register_file_if.slave  rf
);

  localparam int DEPTH = 1 << ADDR_W;

  // Entry 0 is never stored; it reads as zero through the read muxes.
  logic [DATA_W-1:0] regs [1:DEPTH-1];
  logic [DATA_W-1:0] led_q;
  logic [CNT_W-1:0]  wr_count_q;
  logic              wr_accept;
  logic [DATA_W-1:0] stored1;
  logic [DATA_W-1:0] stored2;

  assign wr_accept = rf.wr_en && (rf.wr_addr != ADDR_W'(ZERO_REG_ADDR));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_accept) begin
      for (int i = 1; i < DEPTH; i++) begin
        if (rf.wr_addr == ADDR_W'(i)) begin
          regs[i] <= rf.wr_data;
        end
      end
    end
  end

  // MSB flags "written since reset"; the rest mirrors the last accepted data.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= '0;
    end else if (wr_accept) begin
      led_q <= {1'b1, rf.wr_data[DATA_W-2:0]};
    end
  end

  regfile_sat_counter #(
    .CNT_W (CNT_W)
  ) u_wr_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (wr_accept),
    .count (wr_count_q)
  );

  always_comb begin
    stored1 = '0;
    stored2 = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (rf.rd_addr1 == ADDR_W'(i)) begin
        stored1 = regs[i];
      end
      if (rf.rd_addr2 == ADDR_W'(i)) begin
        stored2 = regs[i];
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rf.rd_data1 = stored1;
    rf.rd_data2 = stored2;
    if (!rst && wr_accept && (rf.wr_addr == rf.rd_addr1)) begin
      rf.rd_data1 = rf.wr_data;
    end
    if (!rst && wr_accept && (rf.wr_addr == rf.rd_addr2)) begin
      rf.rd_data2 = rf.wr_data;
    end
  end
`else
  assign rf.rd_data1 = stored1;
  assign rf.rd_data2 = stored2;
`endif

  assign rf.led      = led_q;
  assign rf.wr_count = wr_count_q;

endmodule : param_register_file

// File: tb/tb_param_register_file.sv
// tb/tb_param_register_file.sv - directed self-checking bench for param_register_file
module tb_param_register_file;
  import regfile_pkg::*;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  param_register_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) rf_bus ();

  param_register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    rf_bus.wr_en   = 1'b1;
    rf_bus.wr_addr = a;
    rf_bus.wr_data = d;
    tick();
    rf_bus.wr_en   = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    rf_bus.wr_en    = 1'b0;
    rf_bus.wr_addr  = '0;
    rf_bus.wr_data  = '0;
    rf_bus.rd_addr1 = '0;
    rf_bus.rd_addr2 = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("init_wr_count", 32'(rf_bus.wr_count), 32'h0);
    check("init_led", 32'(rf_bus.led), 32'h0);

    // Random writes, then a two-cycle reset clears everything.
    for (int i = 0; i < 6; i++) begin
      do_write(ADDR_W'($urandom_range(1, 7)), DATA_W'($urandom));
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int a = 0; a < 8; a++) begin
      rf_bus.rd_addr1 = ADDR_W'(a);
      rf_bus.rd_addr2 = ADDR_W'(7 - a);
      #1;
      check($sformatf("rst_rd1_r%0d", a), 32'(rf_bus.rd_data1), 32'h0);
      check($sformatf("rst_rd2_r%0d", 7 - a), 32'(rf_bus.rd_data2), 32'h0);
    end
    check("rst_led", 32'(rf_bus.led), 32'h0);
    check("rst_wr_count", 32'(rf_bus.wr_count), 32'h0);

    // Basic write/read on both ports.
    do_write(3'd3, 8'h5A);
    rf_bus.rd_addr1 = 3'd3;
    rf_bus.rd_addr2 = 3'd3;
    #1;
    check("basic_rd1", 32'(rf_bus.rd_data1), 32'h5A);
    check("basic_rd2", 32'(rf_bus.rd_data2), 32'h5A);
    check("basic_led", 32'(rf_bus.led), 32'hDA);
    check("basic_wr_count", 32'(rf_bus.wr_count), 32'h1);

    // Write to r0 is ignored.
    do_write(3'd0, 8'hFF);
    rf_bus.rd_addr1 = 3'd0;
    #1;
    check("r0_rd1", 32'(rf_bus.rd_data1), 32'h0);
    check("r0_led", 32'(rf_bus.led), 32'hDA);
    check("r0_wr_count", 32'(rf_bus.wr_count), 32'h1);

    // Same-cycle write/read of r5.
    do_write(3'd5, 8'h10);
    rf_bus.rd_addr1 = 3'd5;
    rf_bus.rd_addr2 = 3'd3;
    rf_bus.wr_en    = 1'b1;
    rf_bus.wr_addr  = 3'd5;
    rf_bus.wr_data  = 8'h21;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_rd1_same", 32'(rf_bus.rd_data1), 32'h21);
`else
    check("bypass_rd1_same", 32'(rf_bus.rd_data1), 32'h10);
`endif
    check("bypass_rd2_other", 32'(rf_bus.rd_data2), 32'h5A);
    tick();
    rf_bus.wr_en = 1'b0;
    #1;
    check("bypass_rd1_next", 32'(rf_bus.rd_data1), 32'h21);
    check("bypass_wr_count", 32'(rf_bus.wr_count), 32'h3);
    check("bypass_led", 32'(rf_bus.led), 32'hA1);

    // Back-to-back writes to r4: last one wins.
    rf_bus.wr_en   = 1'b1;
    rf_bus.wr_addr = 3'd4;
    rf_bus.wr_data = 8'h11;
    tick();
    rf_bus.wr_data = 8'h22;
    tick();
    rf_bus.wr_en    = 1'b0;
    rf_bus.rd_addr2 = 3'd4;
    #1;
    check("b2b_rd2", 32'(rf_bus.rd_data2), 32'h22);
    check("b2b_led", 32'(rf_bus.led), 32'hA2);
    check("b2b_wr_count", 32'(rf_bus.wr_count), 32'h5);

    // 300 accepted writes push the counter to saturation.
    for (int i = 0; i < 300; i++) begin
      do_write(ADDR_W'((i % 7) + 1), DATA_W'(i));
      if (i == 248) begin
        check("sat_pre_wr_count", 32'(rf_bus.wr_count), 32'hFE);
      end
    end
    check("sat_wr_count", 32'(rf_bus.wr_count), 32'hFF);
    do_write(3'd6, 8'h3C);
    rf_bus.rd_addr1 = 3'd6;
    #1;
    check("sat_hold_wr_count", 32'(rf_bus.wr_count), 32'hFF);
    check("sat_last_rd1", 32'(rf_bus.rd_data1), 32'h3C);
    check("sat_last_led", 32'(rf_bus.led), 32'hBC);

    // Reset beats a simultaneous write; no forwarding while in reset.
    rf_bus.rd_addr1 = 3'd2;
    rst             = 1'b1;
    rf_bus.wr_en    = 1'b1;
    rf_bus.wr_addr  = 3'd2;
    rf_bus.wr_data  = 8'h77;
    #1;
    check("coll_rd1_pre", 32'(rf_bus.rd_data1), 32'h27);
    tick();
    rst          = 1'b0;
    rf_bus.wr_en = 1'b0;
    #1;
    check("coll_rd1", 32'(rf_bus.rd_data1), 32'h0);
    check("coll_led", 32'(rf_bus.led), 32'h0);
    check("coll_wr_count", 32'(rf_bus.wr_count), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_param_register_file
